// File: rtl/and_gate_bist.sv
// and_gate_bist
// Clocked built-in self-test engine for a 2-input AND gate. It walks the
// gate's inputs through the full truth table (00, 01, 10, 11), waits
// SETTLE_CYCLES cycles on each vector, samples the gate output and
// compares it against the expected AND result.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a run (accepted only in IDLE)
//   abort      abandon a run in progress (SETTLE/CHECK only)
//   a_o, b_o   drive the gate under test
//   y_i        output of the gate under test
//   busy       high while a run is in progress
//   done       one-cycle pulse after all four vectors are checked
//   pass       last completed run had no mismatches
//   pass_count number of matching vectors
//   fail_count number of mismatching vectors
//   fail_vec   bit k set when vector k mismatched
module and_gate_bist #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a_o,
  output logic       b_o,
  input  logic       y_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] pass_count,
  output logic [2:0] fail_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // The settle counter counts down to zero, so it is loaded with one less
  // than the number of settle cycles.
  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [2:0] pass_count_nxt, fail_count_nxt;
  logic [3:0] fail_vec_nxt;
  logic       expected;
  logic       match;

  // Vector k drives a=k[1], b=k[0]; the AND of those is the reference.
  assign expected = idx[1] & idx[0];
  // Equality rather than identity: an unknown y_i yields an unknown
  // compare, which the if below routes to the mismatch branch.
  assign match    = (y_i == expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      cnt        <= 4'd0;
      a_o        <= 1'b0;
      b_o        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      pass_count <= 3'd0;
      fail_count <= 3'd0;
      fail_vec   <= 4'd0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      a_o        <= a_nxt;
      b_o        <= b_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      pass_count <= pass_count_nxt;
      fail_count <= fail_count_nxt;
      fail_vec   <= fail_vec_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    a_nxt          = a_o;
    b_nxt          = b_o;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    pass_nxt       = pass;
    pass_count_nxt = pass_count;
    fail_count_nxt = fail_count;
    fail_vec_nxt   = fail_vec;

    unique case (state)
      IDLE: begin
        // start outranks abort here; abort has no meaning in IDLE.
        if (start) begin
          state_nxt      = SETTLE;
          idx_nxt        = 2'd0;
          cnt_nxt        = RELOAD;
          a_nxt          = 1'b0;
          b_nxt          = 1'b0;
          busy_nxt       = 1'b1;
          pass_nxt       = 1'b0;
          pass_count_nxt = 3'd0;
          fail_count_nxt = 3'd0;
          fail_vec_nxt   = 4'd0;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          pass_nxt  = 1'b0;
        end else if (cnt == 4'd0) begin
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end

      CHECK: begin
        if (abort) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          pass_nxt  = 1'b0;
        end else begin
          if (match) begin
            pass_count_nxt = pass_count + 3'd1;
          end else begin
            fail_count_nxt    = fail_count + 3'd1;
            fail_vec_nxt[idx] = 1'b1;
          end
          if (idx == 2'd3) begin
            state_nxt = DONE;
          end else begin
            // The next vector goes out on the same edge that records
            // this one's result, so no cycle is lost between vectors.
            idx_nxt   = idx + 2'd1;
            a_nxt     = idx_nxt[1];
            b_nxt     = idx_nxt[0];
            cnt_nxt   = RELOAD;
            state_nxt = SETTLE;
          end
        end
      end

      DONE: begin
        // fail_count already includes the final vector's result here.
        done_nxt  = 1'b1;
        pass_nxt  = (fail_count == 3'd0);
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_and_gate_bist.sv
// Directed testbench for and_gate_bist. Two instances are used: one with
// SETTLE_CYCLES=1 driving a configurable gate model (good, stuck-at-1,
// NAND, unknown on vector 3), and one with SETTLE_CYCLES=3 driving a
// good gate.
module tb_and_gate_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, abort1, a1, b1, y1, busy1, done1, pass1;
  logic [2:0] pc1, fc1;
  logic [3:0] fv1;
  logic       start3, abort3, a3, b3, y3, busy3, done3, pass3;
  logic [2:0] pc3, fc3;
  logic [3:0] fv3;
  int         mode;
  int         errors = 0;
  int         checks = 0;
  int         edges;
  logic       seen_done;

  always #5 clk = ~clk;

  // Gate model: 0 good AND, 1 stuck-at-1, 2 NAND, 3 unknown when a=b=1.
  always_comb begin
    case (mode)
      1:       y1 = 1'b1;
      2:       y1 = ~(a1 & b1);
      3:       y1 = (a1 & b1) ? 1'bx : 1'b0;
      default: y1 = a1 & b1;
    endcase
  end
  assign y3 = a3 & b3;

  and_gate_bist #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .a_o(a1), .b_o(b1), .y_i(y1), .busy(busy1), .done(done1), .pass(pass1),
    .pass_count(pc1), .fail_count(fc1), .fail_vec(fv1)
  );

  and_gate_bist #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .a_o(a3), .b_o(b3), .y_i(y3), .busy(busy3), .done(done3), .pass(pass3),
    .pass_count(pc3), .fail_count(fc3), .fail_vec(fv3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start on dut1, then count edges until done appears (bounded).
  task automatic run1(input int m);
    mode   = m;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    edges  = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      edges++;
      if (done1) begin
        seen_done = 1'b1;
        break;
      end
    end
    check("run1_done_seen", {7'd0, seen_done}, 8'd1);
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    mode = 0;
    #3;
    check("rst_outputs1", {a1, b1, busy1, done1, pass1, fc1}, 8'h00);
    check("rst_counts1", {1'b0, pc1, fv1}, 8'h00);
    check("rst_outputs3", {a3, b3, busy3, done3, pass3, pc3}, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // Good gate: done 9 edges after the start-sampling edge.
    mode = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("good_busy", {7'd0, busy1}, 8'd1);
    check("good_vec0", {6'd0, a1, b1}, 8'd0);
    edges = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      edges++;
      if (done1) begin
        seen_done = 1'b1;
        break;
      end
    end
    check("good_latency", 8'(edges), 8'd9);
    check("good_busy_low", {7'd0, busy1}, 8'd0);
    check("good_pass", {7'd0, pass1}, 8'd1);
    check("good_counts", {1'b0, pc1, 1'b0, fc1}, 8'h40);
    check("good_fvec", {4'd0, fv1}, 8'h00);
    tick();
    check("good_done_pulse", {7'd0, done1}, 8'd0);
    check("good_pass_held", {7'd0, pass1}, 8'd1);

    // Stuck-at-1 gate.
    run1(1);
    check("sa1_pass", {7'd0, pass1}, 8'd0);
    check("sa1_counts", {1'b0, pc1, 1'b0, fc1}, 8'h13);
    check("sa1_fvec", {4'd0, fv1}, 8'h07);

    // NAND in place of AND.
    run1(2);
    check("nand_pass", {7'd0, pass1}, 8'd0);
    check("nand_counts", {1'b0, pc1, 1'b0, fc1}, 8'h04);
    check("nand_fvec", {4'd0, fv1}, 8'h0f);

    // Unknown output on vector 3 must count as a mismatch.
    run1(3);
    check("x_pass", {7'd0, pass1}, 8'd0);
    check("x_counts", {1'b0, pc1, 1'b0, fc1}, 8'h31);
    check("x_fvec", {4'd0, fv1}, 8'h08);

    // SETTLE_CYCLES=3 with a second start while busy.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("s3_vec_e0", {6'd0, a3, b3}, 8'd0);
    edges = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) start3 = 1'b1;
      tick();
      start3 = 1'b0;
      edges++;
      if (edges < 16) check("s3_vec_hold", {6'd0, a3, b3}, 8'(edges / 4));
      if (done3) begin
        seen_done = 1'b1;
        break;
      end
    end
    check("s3_latency", 8'(edges), 8'd17);
    check("s3_result", {pass3, pc3, 1'b0, fc3}, 8'hC0);
    check("s3_fvec", {4'd0, fv3}, 8'h00);

    // Reset during vector 2.
    mode = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_vec2", {6'd0, a1, b1}, 8'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", {a1, b1, busy1, done1, pass1, fc1}, 8'h00);
    check("mid_rst_cnt", {1'b0, pc1, fv1}, 8'h00);
    tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done1) seen_done = 1'b1;
    end
    check("mid_rst_no_done", {7'd0, seen_done}, 8'd0);

    // Abort during vector 1 with a stuck-at-1 gate: vector 0 already failed.
    mode = 1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    check("abort_vec1", {6'd0, a1, b1}, 8'd1);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check("abort_idle", {a1, b1, busy1, done1, pass1, 3'd0}, 8'h00);
    check("abort_partial", {1'b0, pc1, fv1}, 8'h01);
    check("abort_fc", {5'd0, fc1}, 8'd1);
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done1) seen_done = 1'b1;
    end
    check("abort_no_done", {7'd0, seen_done}, 8'd0);
    check("abort_kept", {1'b0, pc1, fv1}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/and_gate_bist.md
Name: and_gate_bist

Overview:
- Sequential built-in self-test engine that sits directly upstream and downstream of and_gate.
- Drives and_gate's a/b inputs through the full 2-input truth table and samples its y output.
- Compares y against the expected AND result and reports pass/fail counts plus a per-vector fail map.
- Gives the AND gate a synthesizable, clocked checker instead of a simulation-only bench.

Parameters:
- SETTLE_CYCLES, 1, cycles a/b are held stable before y is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  synchronous abort of a run in progress.
- a_o  output  1  drives and_gate.a.
- b_o  output  1  drives and_gate.b.
- y_i  input  1  from and_gate.y.
- busy  output  1  high from the cycle after start is accepted until DONE is exited.
- done  output  1  single-cycle pulse when all 4 vectors are checked.
- pass  output  1  high when the last completed run had fail_count==0; held until the next accepted start.
- pass_count  output  3  vectors that matched, 0..4.
- fail_count  output  3  vectors that mismatched, 0..4.
- fail_vec  output  4  bit k set when vector k failed.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - a_o=b_o=0, busy=0, done=0, pass=0, pass_count=0, fail_count=0, fail_vec=0.
  - Vector index = 0, settle counter = 0.
  - Applies immediately and asynchronously, including mid-run; no done is issued for an interrupted run.
- Vectors:
  - 2-bit index k = 0..3, with a_o=k[1] and b_o=k[0].
  - Expected value = a_o & b_o, i.e. 0, 0, 0, 1.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 is accepted.
  - On acceptance: k<=0; a_o,b_o<=vector 0; counts and fail_vec cleared; pass<=0; settle counter<=SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - a_o/b_o are held.
  - The counter decrements each cycle; when it reaches 0, go to CHECK.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK (one cycle):
  - y_i is sampled.
  - Match is an exact compare: y_i equal to the expected value and a known 0/1. An X/Z on y_i counts as a mismatch; the bench uses === semantics and the RTL must not treat X as a match.
  - Match: pass_count++. Mismatch: fail_count++ and fail_vec[k]<=1.
  - If k==3: go to DONE.
  - Otherwise: k++, drive the next vector on the same edge, reload the settle counter, go to SETTLE.
- DONE (one cycle):
  - done=1.
  - pass <= (fail_count==0), using the fully updated count.
  - Go to IDLE; busy drops on the same edge.
- Latency:
  - The edge that samples start is edge 0.
  - done is high in the cycle following edge 4*(SETTLE_CYCLES+1)+1.
  - With SETTLE_CYCLES=1, that is 9 edges after the start-sampling edge.
- start while busy: ignored, with no effect on state or results.
- abort=1 in SETTLE or CHECK:
  - Go to IDLE next edge; busy<=0, a_o=b_o=0, pass<=0.
  - Partial counts and fail_vec are kept; no done is issued.
  - abort in IDLE or DONE is ignored.
- abort and start together in IDLE: start wins.
- Results (pass, counts, fail_vec) are stable from DONE until the next accepted start or reset.
- Invariant: pass_count + fail_count == 4 after every done; the counts never wrap.

Test Plan:
- Good gate (correct and_gate), SETTLE_CYCLES=1, pulse start:
  - done arrives 9 edges after start is sampled.
  - pass=1, pass_count=4, fail_count=0, fail_vec=4'b0000.
- Stuck-at-1 gate (y forced 1): pass=0, pass_count=1, fail_count=3, fail_vec=4'b0111.
- Inverted gate (NAND in place of AND): fail_count=4, fail_vec=4'b1111, pass=0.
- y driven X on vector 3 only: fail_vec=4'b1000, fail_count=1, pass=0; the X is not treated as a match.
- SETTLE_CYCLES=3, start pulsed again while busy:
  - The second start is ignored.
  - done arrives exactly 17 edges after the first start is sampled.
  - a_o/b_o are stable for 4 cycles per vector.
- Mid-run disturbances:
  - rst_n low during vector 2 → all outputs are 0 immediately; no done is issued.
  - In a separate run, abort during vector 1 → IDLE next edge, busy=0, no done, fail_vec keeps partial bits.
